// File: rtl/vector_alu_sequencer.sv
// Vector ALU sequencer: feeds one packed vector operation to the scalar ALU one
// lane per cycle, assembles the per-lane results and summary flags, and hands
// the result vector to write-back through a valid/ready handshake.
module vector_alu_sequencer #(
    parameter int unsigned dataSize = 8,
    parameter int unsigned LANES    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_valid,
    output logic                      start_ready,
    input  logic [2:0]                op_select,
    input  logic                      scalar_mode,
    input  logic [LANES*dataSize-1:0] vec_a,
    input  logic [LANES*dataSize-1:0] vec_b,
    output logic [2:0]                alu_op,
    output logic [dataSize-1:0]       alu_operand1,
    output logic [dataSize-1:0]       alu_operand2,
    input  logic [dataSize-1:0]       alu_result,
    input  logic                      alu_neg,
    input  logic                      alu_zero,
    output logic [LANES*dataSize-1:0] result_vec,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic                      any_neg,
    output logic                      all_zero,
    output logic                      busy
);

    localparam int unsigned VEC_W = LANES * dataSize;
    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic [VEC_W-1:0]   a_q;
    logic [VEC_W-1:0]   b_q;
    logic [2:0]         op_q;
    logic               scalar_q;
    logic               accept;
    logic               result_fire;
    logic               last_lane;

    assign accept      = start_valid && start_ready;
    assign result_fire = result_valid && result_ready;
    assign last_lane   = (idx == IDX_W'(LANES - 1));

    // State register plus handshake/status flags registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            start_ready  <= 1'b1;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_next;
            start_ready  <= (state_next == IDLE);
            busy         <= (state_next != IDLE);
            result_valid <= (state_next == DONE);
        end
    end

    // Next-state decode and the combinational lane select toward the ALU.
    always_comb begin
        state_next   = state;
        alu_op       = '0;
        alu_operand1 = '0;
        alu_operand2 = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                alu_op = op_q;
                for (int i = 0; i < LANES; i++) begin
                    if (idx == IDX_W'(i)) begin
                        alu_operand1 = a_q[i*dataSize +: dataSize];
                        alu_operand2 = b_q[i*dataSize +: dataSize];
                    end
                end
                if (scalar_q) begin
                    alu_operand2 = b_q[dataSize-1:0];
                end
                if (last_lane) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (result_fire) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch on accept, per-lane result capture and flag accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            scalar_q   <= 1'b0;
            result_vec <= '0;
            any_neg    <= 1'b0;
            all_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q        <= vec_a;
                        b_q        <= vec_b;
                        op_q       <= op_select;
                        scalar_q   <= scalar_mode;
                        result_vec <= '0;
                        all_zero   <= 1'b1;
                        any_neg    <= 1'b0;
                        idx        <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (idx == IDX_W'(i)) begin
                            result_vec[i*dataSize +: dataSize] <= alu_result;
                        end
                    end
                    all_zero <= all_zero & alu_zero;
                    any_neg  <= any_neg | alu_neg;
                    idx      <= last_lane ? '0 : idx + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
